// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
// It launches mult/multu/div/divu and holds Busy for a fixed latency before
// committing the result. It also serves mthi/mtlo/mfhi/mflo.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   MDUOp_E [3:0]   E-stage op: 1 mult, 2 multu, 3 div, 4 divu, 5 mthi,
//                   6 mtlo, 7 mfhi, 8 mflo; any other value is a no-op
//   A_E, B_E [31:0] forwarded rs/rt operands
//   start           combinational: a mult/div is accepted this cycle
//   Busy            registered: an operation is in flight
//   HI, LO [31:0]   architectural HI/LO
//   MDU_out [31:0]  combinational: HI for mfhi, LO for mflo, else 0
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp_E,
    input  logic [31:0] A_E,
    input  logic [31:0] B_E,
    output logic        start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_out
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [31:0]        hi, hi_nxt, lo, lo_nxt;
    logic [31:0]        hi_pend, hi_pend_nxt, lo_pend, lo_pend_nxt;

    logic               is_md_op;
    logic               is_mul;
    logic [63:0]        prod;
    logic               a_neg, b_neg;
    logic [31:0]        a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;

    assign is_md_op = (MDUOp_E >= OP_MULT) && (MDUOp_E <= OP_DIVU);
    assign is_mul   = (MDUOp_E == OP_MULT) || (MDUOp_E == OP_MULTU);
    assign start    = is_md_op && (state == IDLE);
    assign Busy     = (state == RUN);
    assign HI       = hi;
    assign LO       = lo;
    assign MDU_out  = (MDUOp_E == OP_MFHI) ? hi :
                      (MDUOp_E == OP_MFLO) ? lo : 32'd0;

    // 64-bit product of sign- or zero-extended operands; low 64 bits are exact.
    assign prod = (MDUOp_E == OP_MULT) ?
                  ({{32{A_E[31]}}, A_E} * {{32{B_E[31]}}, B_E}) :
                  ({32'd0, A_E} * {32'd0, B_E});

    // Signed divide via magnitudes so INT_MIN / -1 wraps to INT_MIN cleanly.
    assign a_neg = (MDUOp_E == OP_DIV) && A_E[31];
    assign b_neg = (MDUOp_E == OP_DIV) && B_E[31];
    assign a_mag = a_neg ? (~A_E + 32'd1) : A_E;
    assign b_mag = b_neg ? (~B_E + 32'd1) : B_E;
    assign b_div = (B_E == 32'd0) ? 32'd1 : b_mag;
    assign q_mag = a_mag / b_div;
    assign r_mag = a_mag % b_div;
    assign quo   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

    // Next-state and data-path update.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hi_nxt      = hi;
        lo_nxt      = lo;
        hi_pend_nxt = hi_pend;
        lo_pend_nxt = lo_pend;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    if (is_mul) begin
                        cnt_nxt     = CNT_W'(MULT_CYCLES);
                        hi_pend_nxt = prod[63:32];
                        lo_pend_nxt = prod[31:0];
                    end else begin
                        cnt_nxt = CNT_W'(DIV_CYCLES);
                        // Divide by zero commits the current HI/LO back unchanged.
                        if (B_E == 32'd0) begin
                            hi_pend_nxt = hi;
                            lo_pend_nxt = lo;
                        end else begin
                            hi_pend_nxt = rem;
                            lo_pend_nxt = quo;
                        end
                    end
                end else if (MDUOp_E == OP_MTHI) begin
                    hi_nxt = A_E;
                end else if (MDUOp_E == OP_MTLO) begin
                    lo_nxt = A_E;
                end
            end
            RUN: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = IDLE;
                    hi_nxt    = hi_pend;
                    lo_nxt    = lo_pend;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            hi_pend <= '0;
            lo_pend <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
            hi_pend <= hi_pend_nxt;
            lo_pend <= lo_pend_nxt;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a scoreboard holds expected HI/LO and
// busy latency per launched op; a monitor pops it when Busy drops.
module tb_mult_div_unit;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  MDUOp_E;
    logic [31:0] A_E, B_E;
    logic        start, Busy;
    logic [31:0] HI, LO, MDU_out;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    int          busy_cnt = 0;
    logic [31:0] hi_m = 32'd0, lo_m = 32'd0;

    always #5 clk = ~clk;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .MDUOp_E(MDUOp_E), .A_E(A_E), .B_E(B_E),
        .start(start), .Busy(Busy), .HI(HI), .LO(LO), .MDU_out(MDU_out)
    );

    // Reference model: 64-bit host arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t    e;
        longint  sa, sb, p, q, r;
        longint unsigned ua, ub, up;
        e.hi = hi_m; e.lo = lo_m; e.cyc = int'(DC);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'(a);          ub = longint'(b);
        case (op)
            4'd1: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; e.cyc = int'(MC); end
            4'd2: begin up = ua * ub; e.hi = up[63:32]; e.lo = up[31:0]; e.cyc = int'(MC); end
            4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; e.hi = r[31:0]; e.lo = q[31:0]; end
            4'd4: if (b != 0) begin e.hi = 32'(ua % ub); e.lo = 32'(ua / ub); end
            default: ;
        endcase
        return e;
    endfunction

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy_cnt = 0;
        end else if (Busy === 1'b1) begin
            busy_cnt++;
        end else if (busy_cnt != 0) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: completion with empty scoreboard");
            end else begin
                e = sbq.pop_front();
                if (HI !== e.hi || LO !== e.lo || busy_cnt != e.cyc) begin
                    errors++;
                    $display("FAIL sb_result: got HI=%h LO=%h busy=%0d, want HI=%h LO=%h busy=%0d",
                             HI, LO, busy_cnt, e.hi, e.lo, e.cyc);
                end
                hi_m = e.hi;
                lo_m = e.lo;
            end
            busy_cnt = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one op for one edge; mult/div launches are pushed to the scoreboard.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        MDUOp_E = op; A_E = a; B_E = b;
        if (op >= 4'd1 && op <= 4'd4) sbq.push_back(model(op, a, b));
        if (op == 4'd5) hi_m = a;
        if (op == 4'd6) lo_m = a;
        step();
        MDUOp_E = 4'd0;
    endtask

    task automatic wait_done(output bit ok);
        for (int i = 0; i < 40 && sbq.size() != 0; i++) step();
        ok = (sbq.size() == 0);
    endtask

    task automatic test_reset();
        reset = 1'b1; MDUOp_E = 4'd1; A_E = 32'd3; B_E = 32'd4;
        #1;
        checks++;
        if (start !== 1'b1) begin errors++; $display("FAIL reset_start: got %b want 1", start); end
        step(); step();
        checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++; $display("FAIL reset_state: Busy=%b HI=%h LO=%h want 0/0/0", Busy, HI, LO);
        end
        MDUOp_E = 4'd0;
        reset = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        step();
    endtask

    task automatic test_mult();
        bit ok;
        MDUOp_E = 4'd1; A_E = 32'hFFFF_FFFE; B_E = 32'd3;
        #1;
        checks++;
        if (start !== 1'b1) begin errors++; $display("FAIL mult_start: got %b want 1", start); end
        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        checks++;
        if (start !== 1'b0 || Busy !== 1'b1 || HI !== 32'd0) begin
            errors++; $display("FAIL mult_launch: start=%b Busy=%b HI=%h want 0/1/0", start, Busy, HI);
        end
        wait_done(ok);
        checks++;
        if (!ok || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
            errors++; $display("FAIL mult_result: HI=%h LO=%h want ffffffff/fffffffa", HI, LO);
        end
        MDUOp_E = 4'd7; #1;
        checks++;
        if (MDU_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mfhi: got %h want ffffffff", MDU_out); end
        MDUOp_E = 4'd0; #1;
        checks++;
        if (MDU_out !== 32'd0) begin errors++; $display("FAIL mdu_out_idle: got %h want 0", MDU_out); end
    endtask

    task automatic test_multu();
        bit ok;
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(ok);
        checks++;
        if (!ok || HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin
            errors++; $display("FAIL multu_result: HI=%h LO=%h want fffffffe/00000001", HI, LO);
        end
    endtask

    task automatic test_div();
        bit ok;
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_done(ok);
        checks++;
        if (!ok || LO !== 32'hFFFF_FFFD || HI !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL div_neg: HI=%h LO=%h want ffffffff/fffffffd", HI, LO);
        end
        issue(4'd4, 32'd7, 32'd2);
        wait_done(ok);
        checks++;
        if (!ok || LO !== 32'd3 || HI !== 32'd1) begin
            errors++; $display("FAIL divu: HI=%h LO=%h want 1/3", HI, LO);
        end
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(ok);
        checks++;
        if (!ok || LO !== 32'h8000_0000 || HI !== 32'd0) begin
            errors++; $display("FAIL div_ovf: HI=%h LO=%h want 0/80000000", HI, LO);
        end
    endtask

    task automatic test_divzero();
        bit ok;
        issue(4'd6, 32'h1234, 32'd0);
        issue(4'd5, 32'h5678, 32'd0);
        checks++;
        if (HI !== 32'h5678 || LO !== 32'h1234) begin
            errors++; $display("FAIL mthi_mtlo: HI=%h LO=%h want 5678/1234", HI, LO);
        end
        issue(4'd3, 32'd99, 32'd0);
        wait_done(ok);
        checks++;
        if (!ok || HI !== 32'h5678 || LO !== 32'h1234) begin
            errors++; $display("FAIL div_zero: HI=%h LO=%h want 5678/1234", HI, LO);
        end
    endtask

    task automatic test_busy_ignore();
        bit ok;
        issue(4'd3, 32'd100, 32'd7);
        step();
        MDUOp_E = 4'd1; A_E = 32'd5; B_E = 32'd5;
        #1;
        checks++;
        if (start !== 1'b0) begin errors++; $display("FAIL busy_start: got %b want 0", start); end
        step();
        MDUOp_E = 4'd5; A_E = 32'hDEAD_BEEF;
        step();
        MDUOp_E = 4'd8; #1;
        checks++;
        if (MDU_out !== 32'h1234 || HI !== 32'h5678) begin
            errors++; $display("FAIL busy_read: MDU_out=%h HI=%h want 1234/5678", MDU_out, HI);
        end
        MDUOp_E = 4'd0;
        wait_done(ok);
        checks++;
        if (!ok || HI !== 32'd2 || LO !== 32'd14) begin
            errors++; $display("FAIL busy_ignore: HI=%h LO=%h want 2/14", HI, LO);
        end
    endtask

    task automatic test_reset_mid();
        issue(4'd3, 32'd1000, 32'd3);
        step(); step();
        reset = 1'b1;
        sbq.delete();
        step();
        checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++; $display("FAIL reset_mid: Busy=%b HI=%h LO=%h want 0/0/0", Busy, HI, LO);
        end
        step();
        reset = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        MDUOp_E = 4'd8; #1;
        checks++;
        if (MDU_out !== 32'd0) begin errors++; $display("FAIL reset_mflo: got %h want 0", MDU_out); end
        MDUOp_E = 4'd0;
        step();
    endtask

    task automatic test_random();
        bit          ok;
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            op = 4'($urandom_range(1, 6));
            a  = $urandom();
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
            if (i % 3 == 0) b = 32'($urandom_range(1, 20));
            issue(op, a, b);
            wait_done(ok);
            checks++;
            if (!ok || HI !== hi_m || LO !== lo_m) begin
                errors++; $display("FAIL random_%0d op=%0d: HI=%h LO=%h want %h/%h", i, op, HI, LO, hi_m, lo_m);
            end
        end
    endtask

    initial begin
        reset = 1'b1; MDUOp_E = 4'd0; A_E = 32'd0; B_E = 32'd0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_divzero();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
